// File: rtl/systolic_seq.sv
// Tile sequencer for a DIM x DIM systolic array: loads DIM A rows, then streams 3*DIM-2 feed cycles.
// Optional tile cycle counter output cyc_cnt is enabled by defining SYSTOLIC_SEQ_CYC_CNT_EN.
module systolic_seq #(
    parameter int unsigned DIM   = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   row_valid,
    output logic                   row_ready,
    output logic                   busy,
    output logic                   done,
    output logic                   mem_en,
    output logic                   mem_wren,
    output logic [$clog2(DIM)-1:0] mem_row,
    output logic                   mac_en,
    output logic                   mac_clr
`ifdef SYSTOLIC_SEQ_CYC_CNT_EN
    ,
    output logic [CNT_W-1:0]       cyc_cnt
`endif
);

    localparam int unsigned ROW_W  = $clog2(DIM);
    localparam int unsigned FEED_W = $clog2(3 * DIM);

    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(DIM - 1);
    localparam logic [FEED_W-1:0] FEED_LAST = FEED_W'(3 * DIM - 3);

    if (DIM < 2 || CNT_W < 1) begin : g_bad_param
        $error("systolic_seq: DIM must be >= 2 and CNT_W >= 1");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FEED = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state, state_nxt;
    logic [ROW_W-1:0]   row_cnt, row_cnt_nxt;
    logic [FEED_W-1:0]  feed_cnt, feed_cnt_nxt;
    logic               first_load, first_load_nxt;

    // State and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            row_cnt    <= '0;
            feed_cnt   <= '0;
            first_load <= 1'b0;
        end else begin
            state      <= state_nxt;
            row_cnt    <= row_cnt_nxt;
            feed_cnt   <= feed_cnt_nxt;
            first_load <= first_load_nxt;
        end
    end

    // Next-state and output decode; handshake outputs follow row_valid within the cycle
    always_comb begin
        state_nxt      = state;
        row_cnt_nxt    = row_cnt;
        feed_cnt_nxt   = feed_cnt;
        first_load_nxt = 1'b0;
        row_ready      = 1'b0;
        busy           = 1'b0;
        done           = 1'b0;
        mem_en         = 1'b0;
        mem_wren       = 1'b0;
        mem_row        = '0;
        mac_en         = 1'b0;
        mac_clr        = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt      = LOAD;
                    first_load_nxt = 1'b1;
                    row_cnt_nxt    = '0;
                    feed_cnt_nxt   = '0;
                end
            end
            LOAD: begin
                row_ready = 1'b1;
                busy      = 1'b1;
                mac_clr   = first_load;
                mem_row   = row_cnt;
                mem_en    = row_valid;
                mem_wren  = row_valid;
                if (row_valid) begin
                    if (row_cnt == ROW_LAST) begin
                        row_cnt_nxt = '0;
                        state_nxt   = FEED;
                    end else begin
                        row_cnt_nxt = row_cnt + ROW_W'(1);
                    end
                end
            end
            FEED: begin
                busy   = 1'b1;
                mem_en = 1'b1;
                mac_en = 1'b1;
                if (feed_cnt == FEED_LAST) begin
                    feed_cnt_nxt = '0;
                    state_nxt    = DONE;
                end else begin
                    feed_cnt_nxt = feed_cnt + FEED_W'(1);
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

`ifdef SYSTOLIC_SEQ_CYC_CNT_EN
    localparam logic [CNT_W-1:0] CYC_MAX = '1;

    // Saturating busy-cycle counter, cleared when a tile is accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_cnt <= '0;
        end else if (state == IDLE && start) begin
            cyc_cnt <= '0;
        end else if (busy && cyc_cnt != CYC_MAX) begin
            cyc_cnt <= cyc_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_systolic_seq.sv
// Self-checking bench for systolic_seq (DIM=8): directed vector table, a hand-written LOAD abort,
// and a randomized run checked cycle by cycle against a timeline model of each tile.
module tb_systolic_seq;

    localparam int unsigned DIM      = 8;
    localparam int unsigned CNT_W    = 16;
    localparam int unsigned ROW_W    = $clog2(DIM);
    localparam int          FEED_LEN = 3 * DIM - 2;
    localparam int          MAXN     = 1500;
    localparam int          CYC_MAX  = (1 << CNT_W) - 1;
`ifdef SYSTOLIC_SEQ_CYC_CNT_EN
    localparam bit HAS_CYC = 1'b1;
`else
    localparam bit HAS_CYC = 1'b0;
`endif

    typedef struct packed {
        logic             row_ready;
        logic             busy;
        logic             done;
        logic             mem_en;
        logic             mem_wren;
        logic [ROW_W-1:0] mem_row;
        logic             mac_en;
        logic             mac_clr;
        logic [CNT_W-1:0] cyc;
    } out_t;

    typedef struct {
        string name;
        int    len;
        int    start0;
        int    start1;
        bit    start_hold;
        int    rv_mode;
        int    rst_at;
        int    exp_done;
        int    exp_first_done;
        int    exp_mac;
        int    exp_xfer;
        int    exp_clr;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             row_valid;
    logic             row_ready;
    logic             busy;
    logic             done;
    logic             mem_en;
    logic             mem_wren;
    logic [ROW_W-1:0] mem_row;
    logic             mac_en;
    logic             mac_clr;
`ifdef SYSTOLIC_SEQ_CYC_CNT_EN
    logic [CNT_W-1:0] cyc_cnt;
`endif

    bit   rst_a   [MAXN];
    bit   start_a [MAXN];
    bit   rv_a    [MAXN];
    bit   chk_a   [MAXN];
    out_t exp_a   [MAXN];

    int n_checks = 0;
    int n_fail   = 0;
    int m_done, m_first_done, m_mac, m_xfer, m_clr;

    systolic_seq #(.DIM(DIM), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .row_valid (row_valid),
        .row_ready (row_ready),
        .busy      (busy),
        .done      (done),
        .mem_en    (mem_en),
        .mem_wren  (mem_wren),
        .mem_row   (mem_row),
        .mac_en    (mac_en),
        .mac_clr   (mac_clr)
`ifdef SYSTOLIC_SEQ_CYC_CNT_EN
        ,
        .cyc_cnt   (cyc_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string what, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", what, act, req);
        end
    endtask

    function automatic out_t sample();
        out_t o;
        o.row_ready = row_ready;
        o.busy      = busy;
        o.done      = done;
        o.mem_en    = mem_en;
        o.mem_wren  = mem_wren;
        o.mem_row   = mem_row;
        o.mac_en    = mac_en;
        o.mac_clr   = mac_clr;
`ifdef SYSTOLIC_SEQ_CYC_CNT_EN
        o.cyc       = cyc_cnt;
`else
        o.cyc       = '0;
`endif
        return o;
    endfunction

    function automatic logic [CNT_W-1:0] sat(input int x);
        if (!HAS_CYC) return '0;
        return CNT_W'((x > CYC_MAX) ? CYC_MAX : x);
    endfunction

    // Lays out each accepted tile on the timeline: DIM transfers, FEED_LEN feed cycles, one done cycle
    function automatic void build_model(input int n);
        int t, c, rows, t0, hold;
        bit ab;
        for (int i = 0; i < n; i++) begin
            exp_a[i] = '0;
            chk_a[i] = 1'b1;
        end
        chk_a[0] = 1'b0;
        hold = 0;
        t    = 1;
        while (t < n) begin
            exp_a[t].cyc = sat(hold);
            if (rst_a[t]) begin
                hold = 0;
                t++;
            end else if (!start_a[t]) begin
                t++;
            end else begin
                t0 = t + 1; c = t0; rows = 0; ab = 1'b0; hold = 0;
                while (c < n && rows < int'(DIM) && !ab) begin
                    exp_a[c].row_ready = 1'b1;
                    exp_a[c].busy      = 1'b1;
                    exp_a[c].mem_en    = rv_a[c];
                    exp_a[c].mem_wren  = rv_a[c];
                    exp_a[c].mem_row   = ROW_W'(rows);
                    exp_a[c].mac_clr   = (c == t0);
                    exp_a[c].cyc       = sat(c - t0);
                    if (rst_a[c]) ab = 1'b1;
                    else if (rv_a[c]) rows++;
                    c++;
                end
                for (int k = 0; k < FEED_LEN && c < n && !ab; k++) begin
                    exp_a[c].busy   = 1'b1;
                    exp_a[c].mem_en = 1'b1;
                    exp_a[c].mac_en = 1'b1;
                    exp_a[c].cyc    = sat(c - t0);
                    if (rst_a[c]) ab = 1'b1;
                    c++;
                end
                if (!ab && c < n) begin
                    exp_a[c].done = 1'b1;
                    exp_a[c].cyc  = sat(c - t0);
                    hold = rst_a[c] ? 0 : c - t0;
                    c++;
                end
                t = c;
            end
        end
    endfunction

    task automatic run_segment(input int n, input string tag);
        out_t act;
        build_model(n);
        m_done = 0; m_first_done = -1; m_mac = 0; m_xfer = 0; m_clr = 0;
        for (int c = 0; c < n; c++) begin
            @(posedge clk); #1;
            rst       = rst_a[c];
            start     = start_a[c];
            row_valid = rv_a[c];
            @(negedge clk);
            act = sample();
            if (chk_a[c]) begin
                n_checks++;
                if (act !== exp_a[c]) begin
                    n_fail++;
                    $display("FAIL %s cycle %0d: outputs got %h, expected %h", tag, c, act, exp_a[c]);
                end
            end
            if (c > 0) begin
                if (act.done) begin
                    m_done++;
                    if (m_first_done < 0) m_first_done = c;
                end
                m_mac  += int'(act.mac_en);
                m_xfer += int'(act.mem_wren);
                m_clr  += int'(act.mac_clr);
            end
        end
    endtask

    task automatic load_vec(input vec_t v);
        for (int c = 0; c < v.len; c++) begin
            rst_a[c]   = (c < 3) || (c == v.rst_at);
            start_a[c] = (c == v.start0) || (c == v.start1) ||
                         (v.start_hold && v.start0 >= 0 && c >= v.start0);
            case (v.rv_mode)
                1:       rv_a[c] = 1'b1;
                2:       rv_a[c] = (v.start0 >= 0) && (c > v.start0) && (((c - v.start0 - 1) % 2) == 0);
                default: rv_a[c] = 1'b0;
            endcase
        end
    endtask

    initial begin
        vec_t vecs[5];
        int   exp_cnt;

        rst = 1'b1; start = 1'b0; row_valid = 1'b0;

        // name, len, start0, start1, hold, rv_mode, rst_at, done, first_done, mac, xfer, clr
        vecs[0] = '{"reset_idle",     14, -1, -1, 1'b0, 0, -1, 0, -1,  0,  0, 0};
        vecs[1] = '{"continuous",     50,  4, -1, 1'b0, 1, -1, 1, 35, 22,  8, 1};
        vecs[2] = '{"stalled",        50,  4, -1, 1'b0, 2, -1, 1, 42, 22,  8, 1};
        vecs[3] = '{"mid_feed_reset", 80,  4, 30, 1'b0, 1, 22, 1, 61, 32, 16, 2};
        vecs[4] = '{"start_held",     80,  4, -1, 1'b1, 1, -1, 2, 35, 47, 24, 3};

        for (int i = 0; i < 5; i++) begin
            load_vec(vecs[i]);
            run_segment(vecs[i].len, vecs[i].name);
            check({vecs[i].name, " done_count"}, m_done,       vecs[i].exp_done);
            check({vecs[i].name, " first_done"}, m_first_done, vecs[i].exp_first_done);
            check({vecs[i].name, " mac_en_cycles"}, m_mac,     vecs[i].exp_mac);
            check({vecs[i].name, " transfers"},  m_xfer,       vecs[i].exp_xfer);
            check({vecs[i].name, " mac_clr_count"}, m_clr,     vecs[i].exp_clr);
        end

        // Abandon a tile in its third LOAD cycle
        @(posedge clk); #1 rst = 1'b1; start = 1'b0; row_valid = 1'b0;
        @(posedge clk); #1 rst = 1'b0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0; row_valid = 1'b1;
        @(negedge clk);
        check("load_abort mac_clr first", int'(mac_clr), 1);
        check("load_abort mem_row first", int'(mem_row), 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("load_abort mem_row second", int'(mem_row), 1);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        check("load_abort busy before reset edge", int'(busy), 1);
        check("load_abort mem_row third", int'(mem_row), 2);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("load_abort busy after reset", int'(busy), 0);
        check("load_abort row_ready after reset", int'(row_ready), 0);
        check("load_abort mem_wren after reset", int'(mem_wren), 0);
        m_done = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            m_done += int'(done) + int'(busy);
        end
        check("load_abort no done or busy", m_done, 0);
        row_valid = 1'b0;

        // Randomized traffic
        for (int c = 0; c < MAXN; c++) begin
            rst_a[c]   = (c < 2) || ($urandom_range(0, 149) == 0);
            start_a[c] = ($urandom_range(0, 3) == 0);
            rv_a[c]    = ($urandom_range(0, 1) == 1);
        end
        run_segment(MAXN, "random");
        exp_cnt = 0;
        for (int c = 1; c < MAXN; c++) exp_cnt += int'(exp_a[c].done);
        check("random done_count", m_done, exp_cnt);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/systolic_seq.md
SYSTOLIC_SEQ -- requirements
Module: systolic_seq

Interface
- REQ-001: Parameter DIM, default 8, is the systolic array dimension, i.e. the rows loaded and the columns streamed per tile.
- REQ-002: Parameter CNT_W, default 16, is the width of the optional cycle counter.
- REQ-003: clk  input  1  sole clock; all state updates on rising edge.
- REQ-004: rst  input  1  reset, synchronous, active-high.
- REQ-005: start  input  1  request to process one tile; sampled only in IDLE.
- REQ-006: row_valid  input  1  host presents one A row this cycle.
- REQ-007: row_ready  output  1  sequencer accepts a row this cycle.
- REQ-008: busy  output  1  tile in progress.
- REQ-009: done  output  1  one-cycle pulse at tile completion.
- REQ-010: mem_en  output  1  shift/enable strobe to the A transpose memory.
- REQ-011: mem_wren  output  1  write-enable to the A transpose memory.
- REQ-012: mem_row  output  $clog2(DIM)  index of the row being written.
- REQ-013: mac_en  output  1  enable to the MAC array.
- REQ-014: mac_clr  output  1  one-cycle accumulator clear to the MAC array.
- REQ-015: cyc_cnt  output  CNT_W  tile cycle count; present only with SYSTOLIC_SEQ_CYC_CNT_EN.

Function
- REQ-016: The FSM SHALL have exactly four states, IDLE, LOAD, FEED and DONE, encoded in registered state.
- REQ-017: In IDLE, start=1 SHALL move the FSM to LOAD on the next edge; start=0 SHALL hold IDLE.
- REQ-018: mac_clr SHALL be 1 only in the first LOAD cycle after start is accepted.
- REQ-019: In LOAD, row_ready SHALL be 1; in all other states it SHALL be 0.
- REQ-020: A row transfer SHALL occur when row_valid and row_ready are both 1; in that same cycle mem_en=1, mem_wren=1 and mem_row=row counter (combinational).
- REQ-021: The LOAD cycles without a transfer SHALL drive mem_en=0 and mem_wren=0, with mem_row holding the counter value.
- REQ-022: The row counter SHALL increment per transfer; the transfer with counter DIM-1 SHALL clear it to 0 and move the FSM to FEED.
- REQ-023: FEED SHALL last exactly 3*DIM-2 cycles, counted by a feed counter of width $clog2(3*DIM), with mem_en=1, mem_wren=0 and mac_en=1 in every FEED cycle.
- REQ-024: After the last FEED cycle, the FSM SHALL enter DONE for exactly one cycle with done=1, then return to IDLE.
- REQ-025: busy SHALL be 1 in LOAD and FEED and 0 in IDLE and DONE.
- REQ-026: Outside LOAD, mem_row SHALL be 0; outside FEED, mac_en SHALL be 0.
- REQ-027: start SHALL be ignored in LOAD, FEED and DONE; start=1 in DONE SHALL NOT shorten the return through IDLE.
- REQ-028: row_valid SHALL be ignored outside LOAD, with no counter change.
- REQ-029: Back-to-back tiles SHALL have at least one IDLE cycle between done and the next mac_clr.

Reset
- REQ-030: While rst=1 at a rising edge, the FSM SHALL go to IDLE and the row and feed counters SHALL go to 0.
- REQ-031: After reset, the outputs row_ready, busy, done, mem_en, mem_wren, mac_en and mac_clr SHALL be 0, and mem_row SHALL be 0.
- REQ-032: rst SHALL take priority over start and row_valid, and a reset in LOAD or FEED SHALL abandon the tile without a done pulse.
- REQ-033: cyc_cnt SHALL reset to 0.

Configuration
- REQ-034: With the macro SYSTOLIC_SEQ_CYC_CNT_EN defined, the module SHALL provide cyc_cnt, behaving as follows:
  - it clears to 0 on start acceptance;
  - it increments every cycle while busy=1;
  - it saturates at 2^CNT_W-1;
  - it holds its value from DONE until the next start.
- REQ-035: Without SYSTOLIC_SEQ_CYC_CNT_EN, the cyc_cnt port and its counter SHALL be absent, and all other behaviour SHALL be identical.

Verification (DIM=8)
- REQ-036: Reset-then-idle check:
  - stimulus: rst held 3 cycles, then released with start=0 for 10 cycles;
  - response: all outputs 0 throughout.
- REQ-037: Continuous load check:
  - stimulus: start pulse, then row_valid=1 continuously;
  - response: mac_clr in cycle 1; mem_wren high 8 cycles with mem_row 0..7; mac_en high for exactly 22 cycles; done pulses once 31 cycles after start.
- REQ-038: Stalled load check:
  - stimulus: row_valid toggling 1,0,1,0 during LOAD;
  - response: exactly 8 transfers; mem_row advances only on transfers; FEED is still 22 cycles.
- REQ-039: Mid-tile reset check:
  - stimulus: rst asserted in the 10th FEED cycle;
  - response: next cycle is IDLE with all outputs 0, no done pulse, and a following tile behaves exactly as in REQ-037.
- REQ-040: Ignored-input check:
  - stimulus: start held high through a whole tile, plus row_valid during FEED;
  - response: start is ignored outside IDLE, row_valid causes no counter change, and one IDLE cycle separates done from the next mac_clr.
- REQ-041: Cycle counter check (with SYSTOLIC_SEQ_CYC_CNT_EN):
  - stimulus: the REQ-037 sequence;
  - response: cyc_cnt=30 at done, held until the next start.
